// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide unsigned adder built by stepping one 4-bit CLA slice across NIB_COUNT nibbles
// cla_adder is the existing 4-bit lookahead slice; the controller owns the only instance.
module cla_adder (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    always_comb begin
        g    = in1 & in2;
        p    = in1 ^ in2;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        out  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module adder_seq_ctrl #(
    parameter int NIB_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIB_COUNT-1:0] in1,
    input  logic [4*NIB_COUNT-1:0] in2,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIB_COUNT-1:0] out,
    output logic                   cout
);
    localparam int W  = 4 * NIB_COUNT;
    localparam int IW = NIB_COUNT > 1 ? $clog2(NIB_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, next_state;
    logic [W-1:0]  op_a, op_b, shadow, merged;
    logic [IW-1:0] idx;
    logic          carry, last;
    logic [3:0]    s_out;
    logic          s_cout;

    cla_adder u_slice (
        .in1  (op_a[4*idx+:4]),
        .in2  (op_b[4*idx+:4]),
        .cin  (carry),
        .out  (s_out),
        .cout (s_cout)
    );

    assign last = idx == IW'(NIB_COUNT - 1);

    // shadow with the current slice already merged, so DONE sees the final nibble on the same edge
    always_comb begin
        merged             = shadow;
        merged[4*idx+:4]   = s_out;
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= next_state;

    always_comb
        next_state = state == IDLE ? (start ? RUN : IDLE)
                   : state == RUN  ? (last ? DONE : RUN)
                   : IDLE;

    always_comb busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            shadow <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            out    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                op_a  <= in1;
                op_b  <= in2;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                shadow <= merged;
                carry  <= s_cout;
                idx    <= last ? '0 : idx + IW'(1);
                if (last) begin
                    out  <= merged;
                    cout <= s_cout;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed table, corner sequences and random ops against an arithmetic model
module tb_adder_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cin = 1'b0, busy, done, cout;
    logic [15:0] in1 = '0, in2 = '0, out;
    logic        s1_start = 1'b0, s1_cin = 1'b0, s1_busy, s1_done, s1_cout;
    logic [3:0]  s1_in1 = '0, s1_in2 = '0, s1_out;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.NIB_COUNT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .cin(cin),
        .busy(busy), .done(done), .out(out), .cout(cout)
    );

    adder_seq_ctrl #(.NIB_COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .in1(s1_in1), .in2(s1_in2), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .out(s1_out), .cout(s1_cout)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        c;
        logic [15:0] eo;
        logic        ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Accept at the coming edge k; done must appear exactly after edge k+4 and busy fall after k+5.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] eo, input logic ec, input string name);
        int early = 0, idle = 0;
        start = 1'b1; in1 = a; in2 = b; cin = c;
        @(negedge clk);
        start = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom); cin = 1'($urandom);
        chk({name, " busy_on"}, busy, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (done) early++;
            if (!busy) idle++;
        end
        chk({name, " early_done"}, early, 0);
        chk({name, " busy_mid"}, idle, 0);
        @(negedge clk);
        chk({name, " done"}, done, 1);
        chk({name, " out"}, out, eo);
        chk({name, " cout"}, cout, ec);
        @(negedge clk);
        chk({name, " busy_off"}, {busy, done}, 0);
        chk({name, " out_hold"}, out, eo);
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] eo, input logic ec, input string name);
        s1_start = 1'b1; s1_in1 = a; s1_in2 = b; s1_cin = c;
        @(negedge clk);
        s1_start = 1'b0; s1_in1 = 4'($urandom); s1_in2 = 4'($urandom);
        chk({name, " busy"}, {s1_busy, s1_done}, 2'b10);
        @(negedge clk);
        chk({name, " done"}, s1_done, 1);
        chk({name, " out"}, s1_out, eo);
        chk({name, " cout"}, s1_cout, ec);
        @(negedge clk);
        chk({name, " idle"}, {s1_busy, s1_done}, 0);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [16:0] exp;
        logic [15:0] a, b;
        logic        c;
        int          dcount;

        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'h2222, 16'h4444, 1'b1, 16'h6667, 1'b0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("reset dut", {busy, done, cout, out}, 0);
        chk("reset dut1", {s1_busy, s1_done, s1_cout, s1_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].eo, tbl[i].ec, $sformatf("vec%0d", i));

        // start pulses and operand changes while busy must not disturb the operation
        start = 1'b1; in1 = 16'h1234; in2 = 16'h0FCD; cin = 1'b0;
        @(negedge clk);
        in1 = 16'hFFFF; in2 = 16'hFFFF; cin = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (done) dcount++;
            if (i == 4) begin
                chk("ignore out", out, 16'h2201);
                start = 1'b0;
            end
        end
        chk("ignore one_done", dcount, 1);
        chk("ignore busy_off", busy, 0);
        repeat (3) @(negedge clk);
        chk("ignore out_hold", {cout, out}, 17'h02201);

        // reset while idx==2 aborts the operation and clears the result
        start = 1'b1; in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort state", {busy, done, cout, out}, 0);
        run_op(16'h2222, 16'h4444, 1'b1, 16'h6667, 1'b0, "after_abort");

        for (int j = 0; j < 20; j++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + 17'(c);
            run_op(a, b, c, exp[15:0], exp[16], $sformatf("rnd%0d", j));
        end

        // start held high: one accept every NIB_COUNT+2 cycles
        start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            in1 = a; in2 = b; cin = c;
            exp = {1'b0, a} + {1'b0, b} + 17'(c);
            @(negedge clk);
            chk($sformatf("cont%0d busy", j), busy, 1);
            in1 = ~a; in2 = ~b; cin = ~c;
            repeat (4) @(negedge clk);
            chk($sformatf("cont%0d done", j), done, 1);
            chk($sformatf("cont%0d result", j), {cout, out}, exp);
            @(negedge clk);
            chk($sformatf("cont%0d idle", j), busy, 0);
        end
        start = 1'b0;
        @(negedge clk);

        op1(4'b0010, 4'b1110, 1'b0, 4'b0000, 1'b1, "n1_a");
        op1(4'b0110, 4'b0110, 1'b0, 4'b1100, 1'b0, "n1_b");
        op1(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, "n1_c");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
